cmp_operand_sequencer: RTL and testbench
========================================

Name: cmp_operand_sequencer

Overview:
- Upstream feeder for the 4-bit magnitude comparators (equal/greater/less).
- Debounces one push-button and captures operands x then y from the slide switches.
- Pulses the comparators' enable for one cycle, then latches the returned flags into a result register for display.
- Sits between board I/O (SW, KEY) and the comparator bank.

Parameters:
- WIDTH, 4, operand width; matches the comparator inputs.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before the debounced level changes (5 ms at 50 MHz).
- CNT_W, 8, width of the completed-comparison counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sw  in  WIDTH  operand source (slide switches), asynchronous to clk.
- key_load_n  in  1  raw load button, active-low (0 = pressed), asynchronous, bouncy.
- x_out  out  WIDTH  captured operand x, to comparator x.
- y_out  out  WIDTH  captured operand y, to comparator y.
- cmp_en  out  1  comparator enable; high only in COMPARE.
- eq_in  in  1  equal flag returned by the comparator.
- gt_in  in  1  greater-than flag returned by the comparator.
- lt_in  in  1  less-than flag returned by the comparator.
- state_out  out  2  current FSM state encoding.
- res_eq  out  1  latched equal result.
- res_gt  out  1  latched greater-than result.
- res_lt  out  1  latched less-than result.
- res_valid  out  1  result register holds a fresh comparison.
- err  out  1  returned flags were not exactly one-hot.
- cmp_count  out  CNT_W  number of completed comparisons, saturating.

Behaviour:
- **Reset** (rst_n=0 at a clk edge) overrides everything, including mid-operation:
  - state=LOAD_X (00); x_out, y_out, res_*, res_valid, err, cmp_count = 0; cmp_en = 0.
  - Synchronizer flops and debounced level reset to 1 (released); debounce counter = 0.
- **Input conditioning:**
  - key_load_n passes through a 2-flop synchronizer.
  - Debounced level updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the old value clears the counter.
  - A press event is a one-cycle pulse on the debounced 1->0 transition.
  - Holding the key produces exactly one event; release produces none.
- **sw** is sampled directly on the press-event cycle; operators hold the switches static while pressing.
- **FSM** (state_out encoding in parentheses):
  - LOAD_X (00): on press, x_out<=sw, go to LOAD_Y.
  - LOAD_Y (01): on press, y_out<=sw, go to COMPARE.
  - COMPARE (10): lasts exactly one cycle.
    - cmp_en=1, decoded from the state register only; x_out/y_out stable.
    - Comparators are combinational; flags are valid in the same cycle.
    - At the end of the cycle: res_eq/gt/lt <= eq_in/gt_in/lt_in; res_valid<=1; err <= (eq_in+gt_in+lt_in != 1); cmp_count increments, saturating at 2^CNT_W-1.
    - Go to SHOW unconditionally.
  - SHOW (11): results held.
    - On press: x_out<=sw; res_valid<=0; go to LOAD_Y.
    - res_eq/gt/lt and err hold their values until the next COMPARE.
- **Ignored events:**
  - A press event coinciding with the COMPARE cycle is ignored, not queued.
  - No state other than COMPARE asserts cmp_en.
- x_out/y_out change only on the captures listed above. y_out keeps its old value until recaptured in LOAD_Y.
- All outputs are registered except cmp_en, which is a pure decode of the state register.

Test Plan:
- Bench setting: DEBOUNCE_CYCLES=4.
- Reset mid-sequence: sw=5, press (state 01), assert rst_n=0 for one edge -> state_out=00, x_out=0, y_out=0, cmp_count=0, res_valid=0.
- Greater path: sw=4'h5 press; sw=4'h3 press; model drives gt_in=1 -> x_out=5, y_out=3; cmp_en high exactly 1 cycle; then res_gt=1, res_eq=0, res_lt=0, res_valid=1, err=0, cmp_count=1, state 11.
- Bounce/hold:
  - Key glitches low for 1–3 cycles repeatedly -> no press event, state unchanged.
  - Key held low for 100 cycles -> exactly one capture.
- Re-run from SHOW:
  - After an equal compare of 9,9 (eq_in=1 -> res_eq=1), set sw=2 and press -> x_out=2, res_valid=0, res_eq still 1, state 01.
  - Then sw=7, press, lt_in=1 -> res_lt=1, cmp_count=2.
- Flag error: model returns gt_in=1, lt_in=1 -> err=1, res_gt=1, res_lt=1, res_valid=1. A following clean compare clears err to 0.
- Counter saturation (CNT_W=2): five complete comparisons -> cmp_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cmp_operand_sequencer.sv
// Operand sequencer for the 4-bit comparator bank: debounces the load key, captures x then y
// from the switches, pulses the comparator enable for one cycle and latches the returned flags.
module cmp_operand_sequencer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             key_load_n,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic             cmp_en,
   input  logic             eq_in,
   input  logic             gt_in,
   input  logic             lt_in,
   output logic [1:0]       state_out,
   output logic             res_eq,
   output logic             res_gt,
   output logic             res_lt,
   output logic             res_valid,
   output logic             err,
   output logic [CNT_W-1:0] cmp_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      LOAD_X  = 2'b00,
      LOAD_Y  = 2'b01,
      COMPARE = 2'b10,
      SHOW    = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              deb_q, deb_d;
   logic [DB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic              press_q, press_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic              res_eq_q, res_eq_d;
   logic              res_gt_q, res_gt_d;
   logic              res_lt_q, res_lt_d;
   logic              res_valid_q, res_valid_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        flag_sum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= LOAD_X;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_cnt_q   <= '0;
         press_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         res_eq_q    <= 1'b0;
         res_gt_q    <= 1'b0;
         res_lt_q    <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         press_q     <= press_d;
         x_q         <= x_d;
         y_q         <= y_d;
         res_eq_q    <= res_eq_d;
         res_gt_q    <= res_gt_d;
         res_lt_q    <= res_lt_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Key conditioning: the debounced level only moves after a full run of disagreeing samples.
   always_comb begin
      sync1_d   = key_load_n;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DB_W'(1);
         end
      end
      press_d = deb_q & ~deb_d;
   end

   assign flag_sum = {1'b0, eq_in} + {1'b0, gt_in} + {1'b0, lt_in};

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      res_eq_d    = res_eq_q;
      res_gt_d    = res_gt_q;
      res_lt_d    = res_lt_q;
      res_valid_d = res_valid_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         LOAD_X: begin
            if (press_q) begin
               x_d     = sw;
               state_d = LOAD_Y;
            end
         end
         LOAD_Y: begin
            if (press_q) begin
               y_d     = sw;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            // A press landing here is dropped on purpose.
            res_eq_d    = eq_in;
            res_gt_d    = gt_in;
            res_lt_d    = lt_in;
            res_valid_d = 1'b1;
            err_d       = (flag_sum != 2'd1);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            state_d     = SHOW;
         end
         SHOW: begin
            if (press_q) begin
               x_d         = sw;
               res_valid_d = 1'b0;
               state_d     = LOAD_Y;
            end
         end
         default: state_d = LOAD_X;
      endcase
   end

   assign cmp_en    = (state_q == COMPARE);
   assign state_out = state_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign res_eq    = res_eq_q;
   assign res_gt    = res_gt_q;
   assign res_lt    = res_lt_q;
   assign res_valid = res_valid_q;
   assign err       = err_q;
   assign cmp_count = cnt_q;

endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// Directed bench for cmp_operand_sequencer with a short debounce and a 2-bit counter.
module tb_cmp_operand_sequencer;

   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] sw = '0;
   logic             key_load_n = 1'b1;
   logic [WIDTH-1:0] x_out, y_out;
   logic             cmp_en;
   logic             eq_in, gt_in, lt_in;
   logic [1:0]       state_out;
   logic             res_eq, res_gt, res_lt, res_valid, err;
   logic [CNT_W-1:0] cmp_count;
   logic             force_err = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt   = 0;

   cmp_operand_sequencer #(
      .WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .key_load_n(key_load_n),
      .x_out(x_out), .y_out(y_out), .cmp_en(cmp_en),
      .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in),
      .state_out(state_out), .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt),
      .res_valid(res_valid), .err(err), .cmp_count(cmp_count)
   );

   always #5 clk = ~clk;

   // Comparator model feeding the flags back combinationally.
   always_comb begin
      if (force_err) begin
         eq_in = 1'b0; gt_in = 1'b1; lt_in = 1'b1;
      end else begin
         eq_in = (x_out == y_out);
         gt_in = (x_out >  y_out);
         lt_in = (x_out <  y_out);
      end
   end

   always @(posedge clk) if (cmp_en) en_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic press(input logic [WIDTH-1:0] val, input int hold);
      @(negedge clk);
      sw = val;
      key_load_n = 1'b0;
      repeat (hold) @(negedge clk);
      key_load_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int en_before;
      logic [CNT_W-1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_state", state_out, 2'b00);
      chk("rst_cmp_en", cmp_en, 1'b0);

      // Reset in the middle of a sequence
      press(4'h5, 10);
      chk("mid_state01", state_out, 2'b01);
      chk("mid_x5", x_out, 4'h5);
      do_reset();
      chk("mid_rst_state", state_out, 2'b00);
      chk("mid_rst_x", x_out, 4'h0);
      chk("mid_rst_y", y_out, 4'h0);
      chk("mid_rst_cnt", cmp_count, 2'd0);
      chk("mid_rst_valid", res_valid, 1'b0);

      // Greater path
      press(4'h5, 10);
      en_before = en_cnt;
      press(4'h3, 10);
      chk("gt_x", x_out, 4'h5);
      chk("gt_y", y_out, 4'h3);
      chk("gt_en_cycles", en_cnt - en_before, 1);
      chk("gt_res_gt", res_gt, 1'b1);
      chk("gt_res_eq", res_eq, 1'b0);
      chk("gt_res_lt", res_lt, 1'b0);
      chk("gt_valid", res_valid, 1'b1);
      chk("gt_err", err, 1'b0);
      chk("gt_cnt", cmp_count, 2'd1);
      chk("gt_state", state_out, 2'b11);
      chk("gt_cmp_en_idle", cmp_en, 1'b0);

      // Bounce and hold from LOAD_X
      do_reset();
      for (int g = 1; g <= 3; g++) begin
         for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            sw = 4'hA;
            key_load_n = 1'b0;
            repeat (g) @(negedge clk);
            key_load_n = 1'b1;
            repeat (4) @(negedge clk);
         end
      end
      repeat (8) @(negedge clk);
      chk("glitch_state", state_out, 2'b00);
      chk("glitch_x", x_out, 4'h0);
      press(4'hC, 100);
      chk("hold_state", state_out, 2'b01);
      chk("hold_x", x_out, 4'hC);

      // Equal compare, then re-run from SHOW
      do_reset();
      press(4'h9, 10);
      press(4'h9, 10);
      chk("eq_res_eq", res_eq, 1'b1);
      chk("eq_cnt", cmp_count, 2'd1);
      press(4'h2, 10);
      chk("rerun_x", x_out, 4'h2);
      chk("rerun_valid", res_valid, 1'b0);
      chk("rerun_eq_held", res_eq, 1'b1);
      chk("rerun_state", state_out, 2'b01);
      chk("rerun_y_held", y_out, 4'h9);
      press(4'h7, 10);
      chk("lt_res_lt", res_lt, 1'b1);
      chk("lt_res_eq", res_eq, 1'b0);
      chk("lt_cnt", cmp_count, 2'd2);

      // Malformed flags, then a clean compare
      force_err = 1'b1;
      press(4'h1, 10);
      press(4'h4, 10);
      chk("ferr_err", err, 1'b1);
      chk("ferr_gt", res_gt, 1'b1);
      chk("ferr_lt", res_lt, 1'b1);
      chk("ferr_valid", res_valid, 1'b1);
      force_err = 1'b0;
      press(4'h6, 10);
      press(4'h6, 10);
      chk("clean_err", err, 1'b0);
      chk("clean_eq", res_eq, 1'b1);

      // Counter saturation
      do_reset();
      for (int k = 0; k < 5; k++) begin
         press(4'(k + 1), 10);
         press(4'h8, 10);
         chk($sformatf("sat_cnt%0d", k), cmp_count, sat_exp[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
